// File: rtl/gtx_pkg.sv
// ============================================================================
//  Module   : gtx_pkg
//  Brief    : Shared header-field widths, magic default and read FSM states
//  Revision : 1.0
// ============================================================================
`default_nettype none

package gtx_pkg;

   localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;
   localparam int          HDR_SEQ_W     = 6;
   localparam int          HDR_LEN_W     = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_FLUSH   = 2'd3
   } state_e;

   // Header word layout: {magic, seq, len}
   function automatic logic [31:0] make_header(
      input logic [15:0]          magic,
      input logic [HDR_SEQ_W-1:0] seq,
      input logic [HDR_LEN_W-1:0] len
   );
      return {magic, seq, len};
   endfunction

endpackage

`default_nettype wire

// File: rtl/gtx_tx_framer_if.sv
// ============================================================================
//  Module   : gtx_tx_framer_if
//  Brief    : AXI4-Stream style data/valid/ready/last bundle
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface gtx_tx_framer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/gtx_len_fifo.sv
// ============================================================================
//  Module   : gtx_len_fifo
//  Brief    : Single-clock descriptor FIFO, show-ahead output, full/empty flags
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gtx_len_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 8
) (
   input  wire              clk,
   input  wire              rst_n,
   input  wire              i_push,
   input  wire [WIDTH-1:0]  i_data,
   input  wire              i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_idx;
   logic [AW-1:0]    r_rd_idx;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_data    = r_mem[r_rd_idx];
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is legal when a pop frees a slot in the same cycle
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_idx] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_idx <= r_wr_idx + AW'(1);
         if (w_do_pop)  r_rd_idx <= r_rd_idx + AW'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/gtx_tx_framer.sv
// ============================================================================
//  Module   : gtx_tx_framer
//  Brief    : Store-and-forward TX framer: buffers packets, prepends a header
//             and releases them to Aurora only while the channel is up
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gtx_tx_framer
   import gtx_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          DEPTH     = 512,
   parameter int          MAX_PKT   = 256,
   parameter int          LEN_DEPTH = 8,
   parameter logic [15:0] MAGIC     = MAGIC_DEFAULT
) (
   input  wire                    user_clk,
   input  wire                    aresetn,
   input  wire                    channel_up,
   gtx_tx_framer_if.slave         s_axis,
   gtx_tx_framer_if.master        m_axis,
   output logic [31:0]            pkt_sent_cnt,
   output logic [15:0]            pkt_drop_cnt,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = HDR_LEN_W;
   localparam int DW = AW + LW;

   // ---------------- write side ----------------
   logic              r_s_tready;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_pkt_start;
   logic [LW-1:0]     r_pkt_len;
   logic              r_dropping;
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     w_level;
   logic              w_acc;
   logic              w_wr_drop;
   logic              w_wr_en;
   logic              w_push;
   logic              w_len_full;
   logic              w_len_empty;
   logic [DW-1:0]     w_desc;
   logic [AW-1:0]     w_desc_start;
   logic [LW-1:0]     w_desc_len;

   // ---------------- read side ----------------
   state_e            r_state;
   state_e            w_state_nxt;
   logic [LW-1:0]     r_cur_len;
   logic [LW-1:0]     r_beat;
   logic [AW-1:0]     r_rd_addr;
   logic [HDR_SEQ_W-1:0] r_seq;
   logic [31:0]       r_sent_cnt;
   logic [15:0]       r_drop_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_ram_q;
   logic              w_pop;
   logic              w_ram_re;
   logic [AW-1:0]     w_ram_addr;
   logic              w_m_tvalid;
   logic [DATA_W-1:0] w_m_tdata;
   logic              w_m_tlast;
   logic              w_last;
   logic              w_pay_hs;
   logic [1:0]        w_drop_inc;
   logic [16:0]       w_drop_sum;

   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign w_acc     = s_axis.tvalid && r_s_tready;
   // Oversize, buffer overflow, or a commit that cannot reach a full descriptor FIFO
   assign w_wr_drop = w_acc && !r_dropping &&
                      ((r_pkt_len == LW'(MAX_PKT)) || (w_level == PW'(DEPTH)) ||
                       (s_axis.tlast && w_len_full && !w_pop));
   assign w_wr_en   = w_acc && !r_dropping && !w_wr_drop;
   assign w_push    = w_wr_en && s_axis.tlast;

   assign s_axis.tready = r_s_tready;
   assign fifo_level    = w_level;

   gtx_len_fifo #(
      .WIDTH (DW),
      .DEPTH (LEN_DEPTH)
   ) u_len_fifo (
      .clk     (user_clk),
      .rst_n   (aresetn),
      .i_push  (w_push),
      .i_data  ({r_pkt_start[AW-1:0], r_pkt_len + LW'(1)}),
      .i_pop   (w_pop),
      .o_data  (w_desc),
      .o_full  (w_len_full),
      .o_empty (w_len_empty)
   );

   assign w_desc_start = w_desc[DW-1:LW];
   assign w_desc_len   = w_desc[LW-1:0];

   always_ff @(posedge user_clk or negedge aresetn) begin
      if (!aresetn) begin
         r_s_tready  <= 1'b0;
         r_wr_ptr    <= '0;
         r_pkt_start <= '0;
         r_pkt_len   <= '0;
         r_dropping  <= 1'b0;
      end else begin
         r_s_tready <= !w_len_full;
         if (w_wr_drop) begin
            r_wr_ptr   <= r_pkt_start;
            r_pkt_len  <= '0;
            r_dropping <= !s_axis.tlast;
         end else if (w_acc && r_dropping) begin
            if (s_axis.tlast) r_dropping <= 1'b0;
         end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (s_axis.tlast) begin
               r_pkt_start <= r_wr_ptr + PW'(1);
               r_pkt_len   <= '0;
            end else begin
               r_pkt_len <= r_pkt_len + LW'(1);
            end
         end
      end
   end

   // Payload RAM with registered read port
   always_ff @(posedge user_clk) begin
      if (w_wr_en)  r_mem[r_wr_ptr[AW-1:0]] <= s_axis.tdata;
      if (w_ram_re) r_ram_q <= r_mem[w_ram_addr];
   end

   assign w_last   = (r_beat == r_cur_len - LW'(1));
   assign w_pay_hs = (r_state == ST_PAYLOAD) && channel_up && m_axis.tready;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = r_rd_addr;
      w_m_tvalid  = 1'b0;
      w_m_tdata   = '0;
      w_m_tlast   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Prefetch the first payload word while the header goes out
            if (!w_len_empty && channel_up) begin
               w_pop       = 1'b1;
               w_ram_re    = 1'b1;
               w_ram_addr  = w_desc_start;
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (!channel_up) begin
               w_state_nxt = ST_FLUSH;
            end else begin
               w_m_tvalid = 1'b1;
               w_m_tdata  = DATA_W'(make_header(MAGIC, r_seq, r_cur_len));
               if (m_axis.tready) w_state_nxt = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (!channel_up) begin
               w_state_nxt = ST_FLUSH;
            end else begin
               w_m_tvalid = 1'b1;
               w_m_tdata  = r_ram_q;
               w_m_tlast  = w_last;
               if (m_axis.tready) begin
                  if (w_last) w_state_nxt = ST_IDLE;
                  else        w_ram_re    = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign m_axis.tvalid = w_m_tvalid;
   assign m_axis.tdata  = w_m_tdata;
   assign m_axis.tlast  = w_m_tlast;

   assign w_drop_inc = {1'b0, w_wr_drop} + {1'b0, (r_state == ST_FLUSH)};
   assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);

   always_ff @(posedge user_clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= ST_IDLE;
         r_cur_len  <= '0;
         r_beat     <= '0;
         r_rd_addr  <= '0;
         r_rd_ptr   <= '0;
         r_seq      <= '0;
         r_sent_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
         if (w_pop) begin
            r_cur_len <= w_desc_len;
            r_beat    <= '0;
            r_rd_addr <= w_desc_start + AW'(1);
         end
         if (w_pay_hs) begin
            r_beat    <= r_beat + LW'(1);
            r_rd_ptr  <= r_rd_ptr + PW'(1);
            r_rd_addr <= r_rd_addr + AW'(1);
            if (w_last) begin
               r_seq      <= r_seq + HDR_SEQ_W'(1);
               r_sent_cnt <= r_sent_cnt + 32'd1;
            end
         end
         // Release whatever of the aborted packet was not yet sent
         if (r_state == ST_FLUSH) r_rd_ptr <= r_rd_ptr + PW'(r_cur_len - r_beat);
      end
   end

   assign pkt_sent_cnt = r_sent_cnt;
   assign pkt_drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gtx_tx_framer.sv
// ============================================================================
//  Module   : tb_gtx_tx_framer
//  Brief    : Randomized scoreboard bench for gtx_tx_framer (DATA_W = 64)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gtx_tx_framer;
   import gtx_pkg::*;

   localparam int DW        = 64;
   localparam int DEPTH     = 512;
   localparam int MAX_PKT   = 256;
   localparam int LEN_DEPTH = 8;

   typedef logic [DW-1:0] word_t;
   typedef word_t wq_t[$];
   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        chup = 1'b0;
   logic [31:0] sent;
   logic [15:0] drop;
   logic [$clog2(DEPTH):0] level;

   always #5 clk = ~clk;

   gtx_tx_framer_if #(.DATA_W(DW)) s_if ();
   gtx_tx_framer_if #(.DATA_W(DW)) m_if ();

   gtx_tx_framer #(
      .DATA_W    (DW),
      .DEPTH     (DEPTH),
      .MAX_PKT   (MAX_PKT),
      .LEN_DEPTH (LEN_DEPTH),
      .MAGIC     (16'hA55A)
   ) dut (
      .user_clk     (clk),
      .aresetn      (rst_n),
      .channel_up   (chup),
      .s_axis       (s_if),
      .m_axis       (m_if),
      .pkt_sent_cnt (sent),
      .pkt_drop_cnt (drop),
      .fifo_level   (level)
   );

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    exp_sent = 0;
   int    exp_drop = 0;
   int    model_seq = 0;
   int    rdy_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic abort_run(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timeout", name);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Reference: a packet of n words becomes one header plus its words, or nothing if oversize
   task automatic expect_pkt(input wq_t pl, input int emit_words);
      beat_t b;
      if (pl.size() > MAX_PKT) begin
         exp_drop++;
         return;
      end
      b.data = word_t'(32'hA55A_0000 + model_seq * 1024 + pl.size());
      b.last = 1'b0;
      exp_q.push_back(b);
      for (int i = 0; i < emit_words; i++) begin
         b.data = pl[i];
         b.last = (i == pl.size() - 1);
         exp_q.push_back(b);
      end
      if (emit_words == pl.size()) begin
         model_seq = (model_seq + 1) % 64;
         exp_sent++;
      end else begin
         exp_drop++;
      end
   endtask

   task automatic send_pkt(input wq_t pl, input bit gaps);
      for (int i = 0; i < pl.size(); i++) begin
         int t;
         s_if.tdata  = pl[i];
         s_if.tlast  = (i == pl.size() - 1);
         s_if.tvalid = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (s_if.tready) begin
               @(posedge clk);
               #1;
               break;
            end
            @(posedge clk);
            #1;
            t++;
            if (t > 3000) abort_run("send_wait");
         end
         s_if.tvalid = 1'b0;
         s_if.tlast  = 1'b0;
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         t++;
         if (t > 5000) abort_run("drain_wait");
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   function automatic wq_t rand_pkt(input int n);
      wq_t q;
      for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
      return q;
   endfunction

   // Downstream ready: always high, or a coin flip each cycle
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) m_if.tready = 1'($urandom_range(0, 1));
      else               m_if.tready = 1'b1;
   end

   // Monitor: pop and compare on every output handshake, and check hold-while-stalled
   logic [DW-1:0] prev_d = '0;
   logic          prev_l = 1'b0;
   logic          prev_stall = 1'b0;

   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (m_if.tvalid && prev_stall) begin
            chk("hold_tdata", m_if.tdata, prev_d);
            chk("hold_tlast", 64'(m_if.tlast), 64'(prev_l));
         end
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got %h expected none", m_if.tdata);
            end else begin
               e = exp_q.pop_front();
               chk("out_tdata", m_if.tdata, e.data);
               chk("out_tlast", 64'(m_if.tlast), 64'(e.last));
            end
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_d     = m_if.tdata;
         prev_l     = m_if.tlast;
      end
   end

   initial begin
      wq_t pl;
      int  sum;
      int  t;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
      chk("rst_s_tready", 64'(s_if.tready), 64'(0));
      chk("rst_sent", 64'(sent), 64'(0));
      chk("rst_drop", 64'(drop), 64'(0));
      chk("rst_level", 64'(level), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single 4-word packet
      chup = 1'b1;
      pl = '{word_t'(1), word_t'(2), word_t'(3), word_t'(4)};
      expect_pkt(pl, pl.size());
      send_pkt(pl, 1'b0);
      wait_drain();
      chk("t1_sent", 64'(sent), 64'(exp_sent));

      // Back-to-back 3-word packets
      pl = '{word_t'(5), word_t'(6), word_t'(7)};
      expect_pkt(pl, pl.size());
      send_pkt(pl, 1'b0);
      pl = '{word_t'(8), word_t'(9), word_t'(10)};
      expect_pkt(pl, pl.size());
      send_pkt(pl, 1'b0);
      wait_drain();

      // Oversize packet followed by a short one
      pl = rand_pkt(MAX_PKT + 1);
      expect_pkt(pl, pl.size());
      send_pkt(pl, 1'b0);
      pl = rand_pkt(2);
      expect_pkt(pl, pl.size());
      send_pkt(pl, 1'b0);
      wait_drain();
      chk("t3_drop", 64'(drop), 64'(exp_drop));
      chk("t3_level", 64'(level), 64'(0));

      // Link down: eight packets fill the descriptor FIFO
      chup = 1'b0;
      sum = 0;
      for (int k = 0; k < LEN_DEPTH; k++) begin
         pl = rand_pkt($urandom_range(1, 6));
         sum += pl.size();
         expect_pkt(pl, pl.size());
         send_pkt(pl, 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("t4_tready_low", 64'(s_if.tready), 64'(0));
      chk("t4_level", 64'(level), 64'(sum));
      chup = 1'b1;
      wait_drain();
      chk("t4_sent", 64'(sent), 64'(exp_sent));

      // Link loss after two of five payload words
      pl = rand_pkt(5);
      expect_pkt(pl, 2);
      send_pkt(pl, 1'b0);
      t = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         t++;
         if (t > 2000) abort_run("t5_wait");
      end
      #1;
      chup = 1'b0;
      @(negedge clk);
      chk("t5_tvalid_drop", 64'(m_if.tvalid), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("t5_drop", 64'(drop), 64'(exp_drop));
      chk("t5_level", 64'(level), 64'(0));
      chup = 1'b1;
      pl = rand_pkt(3);
      expect_pkt(pl, pl.size());
      send_pkt(pl, 1'b0);
      wait_drain();

      // Random backpressure and random packets
      rdy_mode = 1;
      for (int k = 0; k < 12; k++) begin
         pl = rand_pkt($urandom_range(1, 20));
         expect_pkt(pl, pl.size());
         send_pkt(pl, 1'b1);
      end
      wait_drain();
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;

      chk("final_sent", 64'(sent), 64'(exp_sent));
      chk("final_drop", 64'(drop), 64'(exp_drop));
      chk("final_level", 64'(level), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
